// File: rtl/period_counter_pkg.sv
// Shared types and sizing for the period counter memory subsystem.
package period_counter_pkg;

  localparam int PC_MEM_ADDR_W = 10;
  localparam int PC_MEM_DATA_W = 32;

  // Identifies which requester a read return belongs to.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

  // Memory sequencer state: normal arbitration or zero-fill.
  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_INIT = 1'b1
  } pc_state_t;

  // A requester wants the RAM port when it reads or writes.
  function automatic logic port_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/period_counter_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last winner so
// that on a conflict the other requester goes first.
module period_counter_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       favor_b
);

  // 1 means B has priority on the next conflict; reset favours A.
  logic favor_b_q;

  assign favor_b = favor_b_q;

  // Grant the lone requester, or the prioritised one on a conflict.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = favor_b_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Move priority away from whoever just won; hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      favor_b_q <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      favor_b_q <= gnt[0];
    end
  end

endmodule

// File: rtl/period_counter_mem_arbiter.sv
// Shares the single-port period RAM between the capture engine (A) and the
// Avalon host (B), and zero-fills the whole RAM on request.
//
// Handshake: a port requests when read|write is high and must hold its
// address/data/byteenable until a cycle with waitrequest=0, which is the
// cycle the access is accepted. An idle port sees waitrequest=0. A read
// accepted in cycle N returns readdatavalid=1 with readdata in cycle N+1.
module period_counter_mem_arbiter
  import period_counter_pkg::*;
#(
  parameter int ADDR_W = PC_MEM_ADDR_W,
  parameter int DATA_W = PC_MEM_DATA_W,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,

  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,

  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,

  output logic              state_dbg,
  output logic              arb_favor_b_dbg
);

  pc_state_t         state_q;
  pc_state_t         state_d;
  logic [ADDR_W-1:0] fill_q;
  logic              fill_last;
  logic              rd_valid_q;
  port_sel_t         rd_tag_q;
  logic              init_done_q;

  logic [1:0]        req;
  logic [1:0]        arb_req;
  logic [1:0]        gnt;
  logic              arb_advance;
  logic              grant_read;
  port_sel_t         grant_port;

  assign req[0] = port_req(a_read, a_write);
  assign req[1] = port_req(b_read, b_write);

  // The arbiter only sees requests while arbitrating, so the fill owns
  // the RAM port outright and the pointer freezes during INIT.
  assign arb_advance = (state_q == ST_ARB);
  assign arb_req     = arb_advance ? req : 2'b00;

  period_counter_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (arb_advance),
    .gnt     (gnt),
    .favor_b (arb_favor_b_dbg)
  );

  assign fill_last = (fill_q == {ADDR_W{1'b1}});

  // A read-and-write request counts as a write, so only pure reads return data.
  assign grant_read = (gnt[0] & a_read & ~a_write) | (gnt[1] & b_read & ~b_write);
  assign grant_port = gnt[1] ? PORT_B : PORT_A;

  // Next-state logic: init_start is only honoured while arbitrating.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:  if (init_start) state_d = ST_INIT;
      ST_INIT: if (fill_last)  state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // RAM port mux and waitrequests for the current state and grant.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    a_waitrequest  = 1'b0;
    b_waitrequest  = 1'b0;
    if (state_q == ST_INIT) begin
      mem_address    = fill_q;
      mem_byteenable = {BE_W{1'b1}};
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_writedata  = '0;
      a_waitrequest  = 1'b1;
      b_waitrequest  = 1'b1;
    end else begin
      a_waitrequest = req[0] & ~gnt[0];
      b_waitrequest = req[1] & ~gnt[1];
      if (gnt[0]) begin
        mem_address    = a_address;
        mem_byteenable = a_byteenable;
        mem_chipselect = 1'b1;
        mem_write      = a_write;
        mem_writedata  = a_writedata;
      end else if (gnt[1]) begin
        mem_address    = b_address;
        mem_byteenable = b_byteenable;
        mem_chipselect = 1'b1;
        mem_write      = b_write;
        mem_writedata  = b_writedata;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill address: steps once per INIT cycle, parked at zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= '0;
    end else if (state_q == ST_INIT) begin
      fill_q <= fill_q + 1'b1;
    end else begin
      fill_q <= '0;
    end
  end

  // Read return tag: remembers who owns next cycle's mem_readdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= PORT_A;
    end else begin
      rd_valid_q <= grant_read;
      if (grant_read) begin
        rd_tag_q <= grant_port;
      end
    end
  end

  // init_done pulses in the first ARB cycle after the final zero write.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= (state_q == ST_INIT) && fill_last;
    end
  end

  assign init_busy       = (state_q == ST_INIT);
  assign init_done       = init_done_q;
  assign a_readdatavalid = rd_valid_q && (rd_tag_q == PORT_A);
  assign b_readdatavalid = rd_valid_q && (rd_tag_q == PORT_B);
  assign a_readdata      = mem_readdata;
  assign b_readdata      = mem_readdata;
  assign state_dbg       = (state_q == ST_INIT);

endmodule

// File: tb/tb_period_counter_mem_arbiter.sv
// Directed bench for period_counter_mem_arbiter with a behavioural RAM.
module tb_period_counter_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk;
  logic          reset;
  logic [AW-1:0] a_address, b_address;
  logic          a_read, a_write, b_read, b_write;
  logic [BW-1:0] a_byteenable, b_byteenable;
  logic [DW-1:0] a_writedata, b_writedata;
  logic          a_waitrequest, b_waitrequest;
  logic [DW-1:0] a_readdata, b_readdata;
  logic          a_readdatavalid, b_readdatavalid;
  logic          init_start, init_busy, init_done;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic          state_dbg, arb_favor_b_dbg;

  int n_cmp;
  int n_err;

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  period_counter_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_read(a_read), .a_write(a_write),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_read(b_read), .b_write(b_write),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .state_dbg(state_dbg), .arb_favor_b_dbg(arb_favor_b_dbg)
  );

  // Behavioural single-port RAM: byte-lane writes, registered reads.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int i = 0; i < BW; i++)
          if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    a_address = '0; b_address = '0;
    a_byteenable = '0; b_byteenable = '0;
    a_writedata = '0; b_writedata = '0;
    init_start = 0;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  // Runs one zero-fill from the current cycle (init_start raised here) and
  // collects what happened; the calling test does the comparisons.
  task automatic do_fill(output logic start_b_wait, output logic first_b_rdv,
                         output logic [DW-1:0] first_b_data, output int busy_cnt,
                         output int wait_cnt, output int addr_err, output int wr_err,
                         output int early_done, output logic end_done,
                         output logic end_b_wait, output logic finished);
    init_start = 1;
    #1;
    start_b_wait = b_waitrequest;
    busy_cnt = 0; wait_cnt = 0; addr_err = 0; wr_err = 0; early_done = 0;
    end_done = 0; end_b_wait = 1; finished = 0;
    first_b_rdv = 0; first_b_data = '0;
    for (int cyc = 0; cyc < 1100 && !finished; cyc++) begin
      tick();
      init_start = 0;
      #1;
      if (cyc == 0) begin
        first_b_rdv  = b_readdatavalid;
        first_b_data = b_readdata;
      end
      if (init_busy) begin
        if (mem_address !== AW'(busy_cnt)) addr_err++;
        if (mem_write !== 1'b1 || mem_chipselect !== 1'b1 ||
            mem_writedata !== '0 || mem_byteenable !== 4'hF) wr_err++;
        if (b_waitrequest) wait_cnt++;
        if (init_done) early_done++;
        busy_cnt++;
      end else begin
        end_done   = init_done;
        end_b_wait = b_waitrequest;
        finished   = 1;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (init_busy !== 1'b0) begin n_err++; $display("FAIL reset_init_busy got %b want 0", init_busy); end
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done got %b want 0", init_done); end
    n_cmp++; if ({a_readdatavalid, b_readdatavalid} !== 2'b00) begin n_err++; $display("FAIL reset_rdv got %b want 00", {a_readdatavalid, b_readdatavalid}); end
    n_cmp++; if ({mem_chipselect, mem_write} !== 2'b00) begin n_err++; $display("FAIL reset_mem_cs_wr got %b want 00", {mem_chipselect, mem_write}); end
    n_cmp++; if ({a_waitrequest, b_waitrequest} !== 2'b00) begin n_err++; $display("FAIL reset_idle_wait got %b want 00", {a_waitrequest, b_waitrequest}); end
    n_cmp++; if ({state_dbg, arb_favor_b_dbg} !== 2'b00) begin n_err++; $display("FAIL reset_state_ptr got %b want 00", {state_dbg, arb_favor_b_dbg}); end
  endtask

  task automatic test_write_read();
    tick();
    a_write = 1; a_address = 10'd5; a_byteenable = 4'hF; a_writedata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (a_waitrequest !== 1'b0) begin n_err++; $display("FAIL wr_a_wait got %b want 0", a_waitrequest); end
    n_cmp++; if ({mem_chipselect, mem_write, mem_address} !== {2'b11, 10'd5}) begin n_err++; $display("FAIL wr_mem got cs/wr/addr %b/%b/%0d want 1/1/5", mem_chipselect, mem_write, mem_address); end
    tick();
    idle_all();
    b_read = 1; b_address = 10'd5;
    #1;
    n_cmp++; if (b_waitrequest !== 1'b0) begin n_err++; $display("FAIL rd_b_wait got %b want 0", b_waitrequest); end
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rd_mem_write got %b want 0", mem_write); end
    tick();
    idle_all();
    #1;
    n_cmp++; if (b_readdatavalid !== 1'b1) begin n_err++; $display("FAIL rd_b_rdv got %b want 1", b_readdatavalid); end
    n_cmp++; if (b_readdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_b_data got %h want deadbeef", b_readdata); end
    n_cmp++; if (a_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_a_rdv got %b want 0", a_readdatavalid); end
    tick();
    #1;
    n_cmp++; if (b_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_b_rdv_drop got %b want 0", b_readdatavalid); end
  endtask

  // Last winner so far was B, so the first conflict goes to A.
  task automatic test_back_to_back();
    logic exp_a_win;
    for (int i = 0; i < 6; i++) begin
      tick();
      a_read = 1; a_address = 10'd5; b_read = 1; b_address = 10'd5;
      #1;
      exp_a_win = (i % 2 == 0);
      n_cmp++; if (a_waitrequest !== !exp_a_win) begin n_err++; $display("FAIL alt_a_wait cyc %0d got %b want %b", i, a_waitrequest, !exp_a_win); end
      n_cmp++; if (b_waitrequest !== exp_a_win) begin n_err++; $display("FAIL alt_b_wait cyc %0d got %b want %b", i, b_waitrequest, exp_a_win); end
      if (i > 0) begin
        n_cmp++; if ({a_readdatavalid, b_readdatavalid} !== {!exp_a_win, exp_a_win}) begin n_err++; $display("FAIL alt_rdv cyc %0d got %b want %b", i, {a_readdatavalid, b_readdatavalid}, {!exp_a_win, exp_a_win}); end
        n_cmp++; if (a_readdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL alt_data cyc %0d got %h want deadbeef", i, a_readdata); end
      end
    end
    tick();
    idle_all();
    #1;
    n_cmp++; if ({a_readdatavalid, b_readdatavalid} !== 2'b01) begin n_err++; $display("FAIL alt_last_rdv got %b want 01", {a_readdatavalid, b_readdatavalid}); end
  endtask

  task automatic test_byte_lanes();
    tick();
    b_write = 1; b_address = 10'd7; b_byteenable = 4'hF; b_writedata = 32'h11223344;
    tick();
    b_byteenable = 4'h2; b_writedata = 32'hAABBCCDD;
    #1;
    n_cmp++; if (mem_byteenable !== 4'h2) begin n_err++; $display("FAIL be_mem_be got %h want 2", mem_byteenable); end
    tick();
    idle_all();
    b_read = 1; b_address = 10'd7;
    tick();
    idle_all();
    #1;
    n_cmp++; if (b_readdatavalid !== 1'b1) begin n_err++; $display("FAIL be_rdv got %b want 1", b_readdatavalid); end
    n_cmp++; if (b_readdata !== 32'h1122CC44) begin n_err++; $display("FAIL be_data got %h want 1122cc44", b_readdata); end
  endtask

  task automatic test_init();
    logic sbw, fbr, ed, ebw, fin;
    logic [DW-1:0] fbd;
    int bc, wc, ae, we, edn;
    tick();
    b_read = 1; b_address = 10'd5;
    do_fill(sbw, fbr, fbd, bc, wc, ae, we, edn, ed, ebw, fin);
    n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL init_timeout got busy cycles %0d want end within 1100", bc); end
    n_cmp++; if (sbw !== 1'b0) begin n_err++; $display("FAIL init_start_grant b_wait got %b want 0", sbw); end
    n_cmp++; if ({fbr, fbd} !== {1'b1, 32'hDEADBEEF}) begin n_err++; $display("FAIL init_first_rdv got %b/%h want 1/deadbeef", fbr, fbd); end
    n_cmp++; if (bc != 1024) begin n_err++; $display("FAIL init_busy_cycles got %0d want 1024", bc); end
    n_cmp++; if (wc != 1024) begin n_err++; $display("FAIL init_b_wait_cycles got %0d want 1024", wc); end
    n_cmp++; if (ae != 0) begin n_err++; $display("FAIL init_addr_seq got %0d bad want 0", ae); end
    n_cmp++; if (we != 0) begin n_err++; $display("FAIL init_write_ctrl got %0d bad want 0", we); end
    n_cmp++; if (edn != 0) begin n_err++; $display("FAIL init_done_early got %0d want 0", edn); end
    n_cmp++; if (ed !== 1'b1) begin n_err++; $display("FAIL init_done_pulse got %b want 1", ed); end
    n_cmp++; if (ebw !== 1'b0) begin n_err++; $display("FAIL init_b_grant_after got %b want 0", ebw); end
    tick();
    idle_all();
    a_read = 1; a_address = 10'd5;
    #1;
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL init_done_width got %b want 0", init_done); end
    n_cmp++; if ({b_readdatavalid, b_readdata} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL init_b_read got %b/%h want 1/0", b_readdatavalid, b_readdata); end
    tick();
    idle_all();
    #1;
    n_cmp++; if ({a_readdatavalid, a_readdata} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL init_a_read5 got %b/%h want 1/0", a_readdatavalid, a_readdata); end
  endtask

  task automatic test_reset_mid_init();
    logic sbw, fbr, ed, ebw, fin, hit;
    logic [DW-1:0] fbd;
    int bc, wc, ae, we, edn, dseen;
    tick();
    init_start = 1;
    hit = 0;
    for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
      tick();
      init_start = 0;
      #1;
      if (init_busy && mem_address == 10'd300) hit = 1;
    end
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL mid_reach300 got %b want 1", hit); end
    reset = 1;
    tick();
    reset = 0;
    #1;
    n_cmp++; if ({init_busy, init_done} !== 2'b00) begin n_err++; $display("FAIL mid_after_reset got busy/done %b want 00", {init_busy, init_done}); end
    dseen = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      #1;
      if (init_done || init_busy) dseen++;
    end
    n_cmp++; if (dseen != 0) begin n_err++; $display("FAIL mid_no_done got %0d cycles want 0", dseen); end
    do_fill(sbw, fbr, fbd, bc, wc, ae, we, edn, ed, ebw, fin);
    n_cmp++; if (bc != 1024) begin n_err++; $display("FAIL refill_busy_cycles got %0d want 1024", bc); end
    n_cmp++; if ({fin, ed} !== 2'b11) begin n_err++; $display("FAIL refill_done got fin/done %b want 11", {fin, ed}); end
    n_cmp++; if (ae != 0) begin n_err++; $display("FAIL refill_addr_seq got %0d bad want 0", ae); end
  endtask

  task automatic test_single_read_top();
    tick();
    idle_all();
    a_read = 1; a_address = 10'd1023;
    #1;
    n_cmp++; if ({a_waitrequest, mem_chipselect, mem_write, mem_address} !== {3'b010, 10'd1023}) begin n_err++; $display("FAIL top_grant got wait/cs/wr/addr %b/%b/%b/%0d want 0/1/0/1023", a_waitrequest, mem_chipselect, mem_write, mem_address); end
    tick();
    idle_all();
    #1;
    n_cmp++; if ({a_readdatavalid, b_readdatavalid} !== 2'b10) begin n_err++; $display("FAIL top_rdv got %b want 10", {a_readdatavalid, b_readdatavalid}); end
    n_cmp++; if (a_readdata !== 32'h0) begin n_err++; $display("FAIL top_data got %h want 0", a_readdata); end
    tick();
    a_read = 1; a_address = 10'd3; b_read = 1; b_address = 10'd4;
    #1;
    n_cmp++; if (a_readdatavalid !== 1'b0) begin n_err++; $display("FAIL top_rdv_once got %b want 0", a_readdatavalid); end
    n_cmp++; if ({a_waitrequest, b_waitrequest} !== 2'b10) begin n_err++; $display("FAIL top_conflict_b_wins got %b want 10", {a_waitrequest, b_waitrequest}); end
    n_cmp++; if (mem_address !== 10'd4) begin n_err++; $display("FAIL top_conflict_addr got %0d want 4", mem_address); end
    tick();
    idle_all();
    #1;
    n_cmp++; if ({a_readdatavalid, b_readdatavalid} !== 2'b01) begin n_err++; $display("FAIL top_conflict_rdv got %b want 01", {a_readdatavalid, b_readdatavalid}); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1;
    idle_all();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_byte_lanes();
    test_init();
    test_reset_mid_init();
    test_single_read_top();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/period_counter_mem_arbiter.md
# period_counter_mem_arbiter

Two-requester arbiter and initialiser for the period counter's 1024×32 single-port on-chip RAM. It shares the RAM's one port between the capture engine (port A, writes period samples) and the Avalon-MM host (port B, reads and clears results). It uses round-robin arbitration, one grant per cycle and one-cycle read return. It also contains a sequencer that zero-fills the whole RAM on request. It sits between both requesters and the memory's s1 slave.

## Interface
- ADDR_W, 10, word address width; depth = 2^ADDR_W
- DATA_W, 32, data width; byteenable width BE_W = DATA_W/8
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- a_address / b_address  in  ADDR_W  requester word address
- a_read / b_read  in  1  read request
- a_write / b_write  in  1  write request
- a_byteenable / b_byteenable  in  BE_W  byte lanes for writes
- a_writedata / b_writedata  in  DATA_W  write data
- a_waitrequest / b_waitrequest  out  1  request not accepted this cycle
- a_readdata / b_readdata  out  DATA_W  read data
- a_readdatavalid / b_readdatavalid  out  1  readdata valid this cycle
- init_start  in  1  single-cycle pulse: zero-fill the RAM
- init_busy  out  1  zero-fill in progress
- init_done  out  1  one-cycle pulse after the last zero write
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  BE_W  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_readdata  in  DATA_W  from RAM; valid one cycle after the address cycle

## Operation
- FSM has two states: ARB and INIT. Reset enters ARB.
- ARB → INIT when init_start=1. Grants issued in that same cycle still complete.
- INIT → ARB on the cycle after the write to address 2^ADDR_W−1.
- init_start is ignored while in INIT.
- INIT behaviour:
  - fill counter runs 0 → 2^ADDR_W−1, one write per cycle
  - mem_writedata=0, mem_byteenable=all ones, mem_chipselect=1, mem_write=1
  - both waitrequests are held 1; init_busy=1
  - init_done pulses 1 on the INIT→ARB transition cycle
- ARB behaviour:
  - A port requests when read|write. If both read and write are set, it is treated as a write.
  - One requester only: it is granted.
  - Both requesting: the one not granted most recently is granted, and the round-robin pointer updates to the winner.
  - The pointer holds when nothing is granted. At reset the pointer favours A on the first conflict.
  - Granted port: waitrequest=0 and its address/byteenable/writedata/write are muxed to mem_*, with mem_chipselect=1.
  - Requesting but not granted: waitrequest=1; the requester holds its signals.
  - Idle port: waitrequest=0 (Avalon: no request, no effect).
  - Nothing granted: mem_chipselect=0, mem_write=0.
- Read return:
  - A granted read sets a one-bit return tag (A/B) plus a valid flag.
  - Next cycle the tagged port's readdatavalid=1.
  - Both readdata outputs are wired to mem_readdata.
- Reset mid-INIT aborts the fill: RAM contents are undefined; init_done is not pulsed.

## Timing
- Reset values:
  - state=ARB, pointer favours A, fill counter=0, return valid=0
  - init_busy=0, init_done=0, both readdatavalid=0
  - mem_chipselect=0, mem_write=0
- Grant, waitrequest and mem_* are combinational from requests and state; there is no added request latency.
- Read latency from accepted cycle to readdatavalid is exactly 1. Throughput is one access per cycle, back-to-back, including alternating A/B.
- Zero-fill takes exactly 2^ADDR_W cycles of init_busy=1. init_done is high the cycle after the last write, with init_busy=0 in that cycle.
- A read granted in the init_start cycle still returns readdatavalid in the first INIT cycle.

## Structure
- Shared package period_counter_pkg holds:
  - PC_MEM_ADDR_W=10 and PC_MEM_DATA_W=32
  - port-select enum {PORT_A, PORT_B}
  - FSM state enum {ST_ARB, ST_INIT}
- Natural sub-module: period_counter_rr_arb2. It holds the 2-way round-robin grant and the pointer register, with inputs req[1:0] and advance, and output gnt[1:0]. Mux, FSM and read-return logic stay in the top module.

## Test plan
- Reset, then A writes 0xDEADBEEF to addr 5 with byteenable=0xF; next cycle B reads addr 5 → b_waitrequest=0, b_readdatavalid=1 one cycle later, b_readdata=0xDEADBEEF, a_readdatavalid stays 0.
- A and B both request continuously for 6 cycles → grants alternate A,B,A,B,A,B; each loser's waitrequest=1 exactly on its lost cycles.
- Byte lanes: B writes 0x11223344 to addr 7, then B writes 0xAABBCCDD with byteenable=0x2, then B reads addr 7 → readdata 0x1122CC44.
- init_start pulse with B requesting a read throughout → init_busy=1 for 1024 cycles and b_waitrequest=1 for that whole time. init_done pulses once, then B's read is granted. A read of addr 5 afterwards returns 0.
- Assert reset at fill count 300 → init_busy=0 next cycle, no init_done pulse, and a new init_start performs a full 1024-cycle fill.
- Single A read at addr 1023 with B idle → a_readdatavalid on the following cycle only, and the pointer then favours B on the next conflict.
